// File: rtl/jk_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : jk_seq_checker
//  Description : Monitors a JK flip-flop. Each enabled edge predicts the next
//                q from the JK characteristic equation, flags q mismatches and
//                qbar complement violations, counts q toggles/rising edges and
//                enters FAULT once the error count reaches ERR_LIMIT.
//                Optional first-error snapshot enabled by macro JK_SNAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_seq_checker #(
    parameter int CNT_W       = 8,
    parameter int ERR_LIMIT   = 3,
    parameter int SYNC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             qbar,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       err_code,
    output logic [3:0]       snap,
    output logic [15:0]      snap_cyc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_TRACK = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ERR_LIMIT   = CNT_W'(ERR_LIMIT);
    localparam logic [3:0]       c_SYNC_CYCLES = 4'(SYNC_CYCLES);

    state_t           r_state;
    logic             r_pred;
    logic             r_q_prev;
    logic [3:0]       r_sync_cnt;
    logic [CNT_W-1:0] r_toggle_cnt;
    logic [CNT_W-1:0] r_rise_cnt;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [1:0]       r_err_code;

    // JK characteristic equation applied to the current sample
    logic             w_pred_next;
    logic             w_mismatch;
    logic             w_comp;
    logic             w_err_hit;
    logic             w_toggle;
    logic             w_rise;
    logic [CNT_W-1:0] w_err_cnt_inc;
    logic [CNT_W-1:0] w_err_cnt_next;
    logic [CNT_W-1:0] w_toggle_inc;
    logic [CNT_W-1:0] w_rise_inc;

    assign w_pred_next    = (j & ~q) | (~k & q);
    assign w_mismatch     = q ^ r_pred;
    assign w_comp         = ~(qbar ^ q);
    assign w_err_hit      = w_mismatch | w_comp;
    assign w_toggle       = q ^ r_q_prev;
    assign w_rise         = w_toggle & q;
    assign w_err_cnt_inc  = (r_err_cnt == c_CNT_MAX) ? r_err_cnt : r_err_cnt + c_CNT_ONE;
    assign w_err_cnt_next = w_err_hit ? w_err_cnt_inc : r_err_cnt;
    assign w_toggle_inc   = (r_toggle_cnt == c_CNT_MAX) ? r_toggle_cnt : r_toggle_cnt + c_CNT_ONE;
    assign w_rise_inc     = (r_rise_cnt == c_CNT_MAX) ? r_rise_cnt : r_rise_cnt + c_CNT_ONE;

    // Checker FSM with prediction, error and edge counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pred       <= 1'b0;
            r_q_prev     <= 1'b0;
            r_sync_cnt   <= 4'd0;
            r_toggle_cnt <= '0;
            r_rise_cnt   <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_err_code   <= 2'b00;
        end else if (clr) begin
            // clr wins over any error or count seen on the same edge
            r_state      <= S_SYNC;
            r_sync_cnt   <= 4'd1;
            r_pred       <= w_pred_next;
            r_q_prev     <= q;
            r_toggle_cnt <= '0;
            r_rise_cnt   <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= '0;
            r_err_code   <= 2'b00;
        end else if (en) begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_SYNC;
                    r_sync_cnt <= 4'd1;
                    r_pred     <= w_pred_next;
                    r_q_prev   <= q;
                end
                S_SYNC: begin
                    r_pred   <= w_pred_next;
                    r_q_prev <= q;
                    if (r_sync_cnt == c_SYNC_CYCLES) begin
                        r_state <= S_TRACK;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + 4'd1;
                    end
                end
                S_TRACK: begin
                    r_pred   <= w_pred_next;
                    r_q_prev <= q;
                    if (w_err_hit) begin
                        r_err      <= 1'b1;
                        r_err_cnt  <= w_err_cnt_inc;
                        r_err_code <= {w_comp, w_mismatch};
                    end
                    if (w_toggle) begin
                        r_toggle_cnt <= w_toggle_inc;
                    end
                    if (w_rise) begin
                        r_rise_cnt <= w_rise_inc;
                    end
                    if (w_err_cnt_next >= c_ERR_LIMIT) begin
                        r_state <= S_FAULT;
                    end
                end
                S_FAULT: begin
                    // frozen until reset or clr
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign toggle_cnt = r_toggle_cnt;
    assign rise_cnt   = r_rise_cnt;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign err_code   = r_err_code;

`ifdef JK_SNAP_EN
    logic        r_j_prev;
    logic        r_k_prev;
    logic [15:0] r_cyc_cnt;
    logic [3:0]  r_snap;
    logic [15:0] r_snap_cyc;
    logic        w_err_evt;

    assign w_err_evt = (r_state == S_TRACK) & w_err_hit;

    // First-error snapshot and free-running enabled-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_j_prev   <= 1'b0;
            r_k_prev   <= 1'b0;
            r_cyc_cnt  <= 16'd0;
            r_snap     <= 4'd0;
            r_snap_cyc <= 16'd0;
        end else if (clr) begin
            r_j_prev   <= j;
            r_k_prev   <= k;
            r_cyc_cnt  <= 16'd0;
            r_snap     <= 4'd0;
            r_snap_cyc <= 16'd0;
        end else if (en) begin
            r_j_prev  <= j;
            r_k_prev  <= k;
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
            // r_err is still clear only before the first error
            if (w_err_evt && !r_err) begin
                r_snap     <= {r_j_prev, r_k_prev, r_pred, q};
                r_snap_cyc <= r_cyc_cnt;
            end
        end
    end

    assign snap     = r_snap;
    assign snap_cyc = r_snap_cyc;
`else
    assign snap     = 4'd0;
    assign snap_cyc = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jk_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_seq_checker
//  Description : Directed bench for jk_seq_checker. Two instances (CNT_W=8
//                and CNT_W=3) see the same stimulus; a behavioural model
//                tracks both and is compared every cycle, and literal
//                expectations pin the model at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_seq_checker;

    localparam int c_ERR_LIMIT   = 3;
    localparam int c_SYNC_CYCLES = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr, j, k, q, qbar;

    logic [1:0]  state_a, state_b;
    logic [7:0]  tog_a, rise_a, ecnt_a;
    logic [2:0]  tog_b, rise_b, ecnt_b;
    logic        err_a, err_b;
    logic [1:0]  code_a, code_b;
    logic [3:0]  snap_a, snap_b;
    logic [15:0] scyc_a, scyc_b;

    jk_seq_checker #(.CNT_W(8), .ERR_LIMIT(c_ERR_LIMIT), .SYNC_CYCLES(c_SYNC_CYCLES)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q), .qbar(qbar),
        .state(state_a), .toggle_cnt(tog_a), .rise_cnt(rise_a), .err(err_a),
        .err_cnt(ecnt_a), .err_code(code_a), .snap(snap_a), .snap_cyc(scyc_a)
    );

    jk_seq_checker #(.CNT_W(3), .ERR_LIMIT(c_ERR_LIMIT), .SYNC_CYCLES(c_SYNC_CYCLES)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .j(j), .k(k), .q(q), .qbar(qbar),
        .state(state_b), .toggle_cnt(tog_b), .rise_cnt(rise_b), .err(err_b),
        .err_cnt(ecnt_b), .err_code(code_b), .snap(snap_b), .snap_cyc(scyc_b)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    bit fq       = 1'b0;   // true state of the monitored flop

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 -> CNT_W=8, index 1 -> CNT_W=3
    int m_state[2], m_tog[2], m_rise[2], m_err[2], m_ecnt[2], m_code[2];
    int m_pred[2], m_qp[2], m_sync[2], m_jp[2], m_kp[2], m_cyc[2], m_snap[2], m_scyc[2];
    int maxv[2] = '{255, 7};

    always @(posedge clk) begin : model
        int p, mis, cmp;
        p   = int'((j & ~q) | (~k & q));
        mis = 0;
        cmp = 0;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_state[i] = 0; m_tog[i] = 0; m_rise[i] = 0; m_err[i] = 0; m_ecnt[i] = 0;
                m_code[i] = 0; m_pred[i] = 0; m_qp[i] = 0; m_sync[i] = 0; m_jp[i] = 0;
                m_kp[i] = 0; m_cyc[i] = 0; m_snap[i] = 0; m_scyc[i] = 0;
            end else if (clr) begin
                m_state[i] = 1; m_sync[i] = 1; m_tog[i] = 0; m_rise[i] = 0; m_err[i] = 0;
                m_ecnt[i] = 0; m_code[i] = 0; m_snap[i] = 0; m_scyc[i] = 0; m_cyc[i] = 0;
                m_pred[i] = p; m_qp[i] = int'(q); m_jp[i] = int'(j); m_kp[i] = int'(k);
            end else if (en) begin
                if (m_state[i] == 2) begin
                    mis = (int'(q) != m_pred[i]) ? 1 : 0;
                    cmp = (qbar == q) ? 1 : 0;
                    if (mis + cmp > 0) begin
                        if (m_err[i] == 0) begin
                            m_snap[i] = m_jp[i] * 8 + m_kp[i] * 4 + m_pred[i] * 2 + int'(q);
                            m_scyc[i] = m_cyc[i];
                        end
                        m_err[i]  = 1;
                        m_ecnt[i] = (m_ecnt[i] + 1 > maxv[i]) ? maxv[i] : m_ecnt[i] + 1;
                        m_code[i] = cmp * 2 + mis;
                    end
                    if (int'(q) != m_qp[i]) begin
                        m_tog[i] = (m_tog[i] + 1 > maxv[i]) ? maxv[i] : m_tog[i] + 1;
                        if (q) m_rise[i] = (m_rise[i] + 1 > maxv[i]) ? maxv[i] : m_rise[i] + 1;
                    end
                    if (m_ecnt[i] >= c_ERR_LIMIT) m_state[i] = 3;
                end else if (m_state[i] == 1) begin
                    if (m_sync[i] == c_SYNC_CYCLES) m_state[i] = 2;
                    else m_sync[i]++;
                end else if (m_state[i] == 0) begin
                    m_state[i] = 1;
                    m_sync[i]  = 1;
                end
                m_pred[i] = p; m_qp[i] = int'(q); m_jp[i] = int'(j); m_kp[i] = int'(k);
                m_cyc[i]  = (m_cyc[i] + 1) % 65536;
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("a_state", 32'(state_a), m_state[0]);
            check("a_tog",   32'(tog_a),   m_tog[0]);
            check("a_rise",  32'(rise_a),  m_rise[0]);
            check("a_err",   32'(err_a),   m_err[0]);
            check("a_ecnt",  32'(ecnt_a),  m_ecnt[0]);
            check("a_code",  32'(code_a),  m_code[0]);
            check("b_state", 32'(state_b), m_state[1]);
            check("b_tog",   32'(tog_b),   m_tog[1]);
            check("b_rise",  32'(rise_b),  m_rise[1]);
            check("b_err",   32'(err_b),   m_err[1]);
            check("b_ecnt",  32'(ecnt_b),  m_ecnt[1]);
            check("b_code",  32'(code_b),  m_code[1]);
`ifdef JK_SNAP_EN
            check("a_snap",  32'(snap_a),  m_snap[0]);
            check("a_scyc",  32'(scyc_a),  m_scyc[0]);
            check("b_snap",  32'(snap_b),  m_snap[1]);
            check("b_scyc",  32'(scyc_b),  m_scyc[1]);
`else
            check("a_snap0", 32'(snap_a),  0);
            check("a_scyc0", 32'(scyc_a),  0);
`endif
        end
    end

    // One clock: drive at negedge, clock the flop at posedge, return at negedge
    task automatic step(input bit ie, input bit iclr, input bit ij, input bit ik,
                        input bit iflip, input bit icomp);
        en   = ie;
        clr  = iclr;
        j    = ij;
        k    = ik;
        q    = fq ^ iflip;
        qbar = icomp ? (fq ^ iflip) : ~(fq ^ iflip);
        @(posedge clk);
        fq = (ij & ~fq) | (~ik & fq);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; j = 1'b0; k = 1'b0; q = 1'b0; qbar = 1'b1;
        @(negedge clk);
        // reset with random inputs
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk_on = 1'b1;
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        check("rst_state", 32'(state_a), 0);
        check("rst_tog",   32'(tog_a),   0);
        check("rst_err",   32'(err_a),   0);

        // toggle run: 2 edges to reach TRACK, then 9 tracked toggles
        rst_n = 1'b1;
        fq    = 1'b0;
        for (int n = 0; n < 11; n++) step(1, 0, 1, 1, 0, 0);
        check("tgl_state", 32'(state_a), 2);
        check("tgl_tog",   32'(tog_a),   9);
        check("tgl_rise",  32'(rise_a),  4);
        check("tgl_err",   32'(err_a),   0);
        check("tgl_tog_b", 32'(tog_b),   7);

        // injected q mismatch with J=1 K=0 on the 14th enabled edge
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 0, 0);
        check("mis_err",   32'(err_a),   1);
        check("mis_code",  32'(code_a),  1);
        check("mis_ecnt",  32'(ecnt_a),  1);
        check("mis_state", 32'(state_a), 2);
`ifdef JK_SNAP_EN
        check("mis_snap",  32'(snap_a),  4'b1010);
        check("mis_scyc",  32'(scyc_a),  13);
`endif

        // clr back to SYNC, one edge to TRACK, then three complement faults
        step(1, 1, 1, 0, 0, 0);
        check("clr_state", 32'(state_a), 1);
        check("clr_ecnt",  32'(ecnt_a),  0);
        step(1, 0, 1, 0, 0, 0);
        check("trk_state", 32'(state_a), 2);
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        check("cmp2_state", 32'(state_a), 2);
        check("cmp2_ecnt",  32'(ecnt_a),  2);
        step(1, 0, 1, 0, 0, 1);
        check("cmp3_state", 32'(state_a), 3);
        check("cmp3_code",  32'(code_a),  2'b10);
        check("cmp3_ecnt",  32'(ecnt_a),  3);
`ifdef JK_SNAP_EN
        check("cmp_snap",   32'(snap_a),  4'b1011);
        check("cmp_scyc",   32'(scyc_a),  1);
`endif
        step(1, 0, 1, 0, 1, 1);
        step(1, 0, 1, 0, 1, 1);
        check("flt_ecnt",   32'(ecnt_a),  3);
        check("flt_code",   32'(code_a),  2'b10);
        check("flt_state",  32'(state_a), 3);

        // clr with en low, then 5 idle edges, then one enabled edge
        step(0, 1, 1, 0, 0, 0);
        check("clr0_state", 32'(state_a), 1);
        check("clr0_ecnt",  32'(ecnt_a),  0);
        check("clr0_err",   32'(err_a),   0);
        for (int n = 0; n < 5; n++) step(0, 0, 1, 0, 0, 0);
        check("hold_state", 32'(state_a), 1);
        step(1, 0, 1, 1, 0, 0);
        check("en_state",   32'(state_a), 2);

        // long toggle run: CNT_W=3 instance saturates at 7
        for (int n = 0; n < 20; n++) step(1, 0, 1, 1, 0, 0);
        check("sat_tog_a",  32'(tog_a),  20);
        check("sat_rise_a", 32'(rise_a), 10);
        check("sat_tog_b",  32'(tog_b),  7);
        check("sat_rise_b", 32'(rise_b), 7);

        // reset in the middle of TRACK
        rst_n = 1'b0;
        step(1, 0, 1, 1, 0, 0);
        check("mrst_state", 32'(state_a), 0);
        check("mrst_tog",   32'(tog_a),   0);
        rst_n = 1'b1;
        step(1, 0, 1, 1, 0, 0);
        check("mrst_sync",  32'(state_a), 1);

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
